// File: rtl/regfile_mp_pkg.sv
// Shared types for the multi-port register file: clear-sweep FSM states and depth derivation.
package regfile_mp_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Soft-clear sequencer: walks every entry index once, then pulses done.
module regfile_clr_fsm #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] clr_idx,
  output logic          clr_we
);
  import regfile_mp_pkg::*;

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Counter holds at the last index on exit; it is re-zeroed on the next start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr) begin
          state_d = CLR_SWEEP;
          cnt_d   = '0;
        end
      end
      CLR_SWEEP: begin
        if (cnt_q == {AW{1'b1}}) state_d = CLR_DONE;
        else                     cnt_d   = cnt_q + AW'(1);
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
    busy_d = (state_d == CLR_SWEEP);
    done_d = (state_d == CLR_DONE);
  end

  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign clr_idx  = cnt_q;
  assign clr_we   = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// ID-stage register file: NRD async read ports with write-first bypass,
// per-entry pending scoreboard and a sequential soft-clear sweep.
module regfile_mp #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRD     = 2,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              RegWr,
  input  logic [AW-1:0]     Rw,
  input  logic [DW-1:0]     Di,
  input  logic [NRD*AW-1:0] Ra,
  output logic [NRD*DW-1:0] Rd,
  output logic [NRD-1:0]    RdPend,
  input  logic              SbSet,
  input  logic [AW-1:0]     SbAddr,
  input  logic              Clr,
  output logic              ClrBusy,
  output logic              ClrDone
);
  import regfile_mp_pkg::*;

  localparam int unsigned DEPTH = depth_of(AW);
  localparam bit          ZR0   = (ZERO_R0 != 0);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             clr_busy, clr_we;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok, sb_ok;
  logic [AW-1:0]    ra_k;

  regfile_clr_fsm #(.AW(AW)) u_clr_fsm (
    .clk      (CLK),
    .rst_n    (Resetn),
    .clr      (Clr),
    .clr_busy (clr_busy),
    .clr_done (ClrDone),
    .clr_idx  (clr_idx),
    .clr_we   (clr_we)
  );

  assign ClrBusy = clr_busy;
  assign wr_ok   = RegWr && !clr_busy && !(ZR0 && (Rw == '0));
  assign sb_ok   = SbSet && !clr_busy && !(ZR0 && (SbAddr == '0));

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  // Scoreboard set is applied after the write so a new producer wins.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (clr_we) begin
      mem_d[clr_idx]  = '0;
      pend_d[clr_idx] = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[Rw]  = Di;
        pend_d[Rw] = 1'b0;
      end
      if (sb_ok) pend_d[SbAddr] = 1'b1;
    end
  end

  // Pending flags reflect stored state only; bypass does not hide a hazard.
  always_comb begin
    Rd     = '0;
    RdPend = '0;
    ra_k   = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      ra_k = Ra[k*AW +: AW];
      if (Resetn) begin
        RdPend[k] = pend_q[ra_k];
        if (clr_busy || (ZR0 && (ra_k == '0))) Rd[k*DW +: DW] = '0;
        else if (wr_ok && (Rw == ra_k))        Rd[k*DW +: DW] = Di;
        else                                   Rd[k*DW +: DW] = mem_q[ra_k];
      end
    end
  end

endmodule
